host_wr_msix_port: RTL and testbench

//  Synthesisable host-side write port with MSI-X detection. Buffers posted DW writes from the

---
 rtl/host_wr_msix_port.sv | 116 +++++++++++
 tb/tb_host_wr_msix_port.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/host_wr_msix_port.sv
// rtl/host_wr_msix_port.sv - posted-write FIFO to host memory with MSI-X address/data match detection
module host_wr_msix_port #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 32,
    parameter int NUM_VEC    = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    input  logic [ADDR_W-1:0]           wr_addr,
    input  logic [DATA_W-1:0]           wr_data,
    input  logic [DATA_W/8-1:0]         wr_be,
    output logic                        mem_valid,
    input  logic                        mem_ready,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_data,
    output logic [DATA_W/8-1:0]         mem_be,
    input  logic [NUM_VEC-1:0]          vec_en,
    input  logic [NUM_VEC*ADDR_W-1:0]   vec_addr,
    input  logic [NUM_VEC*DATA_W-1:0]   vec_data,
    input  logic [NUM_VEC-1:0]          intr_clr,
    output logic [NUM_VEC-1:0]          intr_pend,
    output logic                        intr_any,
    output logic [NUM_VEC*CNT_W-1:0]    hit_cnt
);

    localparam int BE_W  = DATA_W / 8;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] COUNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);

    logic [ADDR_W-1:0] addr_mem [FIFO_DEPTH];
    logic [DATA_W-1:0] data_mem [FIFO_DEPTH];
    logic [BE_W-1:0]   be_mem   [FIFO_DEPTH];

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic [NUM_VEC-1:0] hit;
    logic [CNT_W-1:0]  cnt_q [NUM_VEC];

    // Flags come from the registered count only, so a pop while full does not reopen wr_ready this cycle.
    assign full      = (count == COUNT_FULL);
    assign empty     = (count == '0);
    assign wr_ready  = ~full;
    assign mem_valid = ~empty;
    assign push      = wr_valid & ~full;
    assign pop       = ~empty & mem_ready;

    assign mem_addr = empty ? '0 : addr_mem[rd_ptr];
    assign mem_data = empty ? '0 : data_mem[rd_ptr];
    assign mem_be   = empty ? '0 : be_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= wr_addr;
            data_mem[wr_ptr] <= wr_data;
            be_mem[wr_ptr]   <= wr_be;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Match is taken on the retiring head, so the interrupt never overtakes its own write.
    for (genvar i = 0; i < NUM_VEC; i++) begin : g_vec
        assign hit[i] = pop & vec_en[i] & (&mem_be)
                      & (mem_addr == vec_addr[i*ADDR_W +: ADDR_W])
                      & (mem_data == vec_data[i*DATA_W +: DATA_W]);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q[i] <= '0;
            end else if (hit[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
                cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            end
        end

        assign hit_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
    end

    // A hit in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            intr_pend <= '0;
        end else begin
            intr_pend <= (intr_pend & ~intr_clr) | hit;
        end
    end

    assign intr_any = |intr_pend;

endmodule

// File: tb/tb_host_wr_msix_port.sv
// tb/tb_host_wr_msix_port.sv - scoreboard bench for host_wr_msix_port
module tb_host_wr_msix_port;

    logic         clk;
    logic         rst_n;
    logic         wr_valid;
    logic         wr_ready;
    logic [63:0]  wr_addr;
    logic [31:0]  wr_data;
    logic [3:0]   wr_be;
    logic         mem_valid;
    logic         mem_ready;
    logic [63:0]  mem_addr;
    logic [31:0]  mem_data;
    logic [3:0]   mem_be;
    logic [3:0]   vec_en;
    logic [255:0] vec_addr;
    logic [127:0] vec_data;
    logic [3:0]   intr_clr;
    logic [3:0]   intr_pend;
    logic         intr_any;
    logic [63:0]  hit_cnt;

    typedef struct packed {
        logic [63:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } wr_t;

    wr_t sb[$];
    wr_t mon_exp;
    int  checks   = 0;
    int  failures = 0;
    int  retired  = 0;

    host_wr_msix_port dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_be     (wr_be),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_be    (mem_be),
        .vec_en    (vec_en),
        .vec_addr  (vec_addr),
        .vec_data  (vec_data),
        .intr_clr  (intr_clr),
        .intr_pend (intr_pend),
        .intr_any  (intr_any),
        .hit_cnt   (hit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: accepted writes are queued, retired writes must match the queue head.
    always @(negedge clk) begin
        if (rst_n && wr_valid && wr_ready) begin
            sb.push_back('{wr_addr, wr_data, wr_be});
        end
        if (rst_n && mem_valid && mem_ready) begin
            checks++;
            retired++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL retire_order: got unexpected write addr=%h, required none", mem_addr);
            end else begin
                mon_exp = sb.pop_front();
                if ({mem_addr, mem_data, mem_be} !== mon_exp) begin
                    failures++;
                    $display("FAIL retire_order: got %h/%h/%h required %h/%h/%h",
                             mem_addr, mem_data, mem_be, mon_exp.addr, mon_exp.data, mon_exp.be);
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the write is accepted.
    task automatic do_write(input logic [63:0] a, input logic [31:0] d, input logic [3:0] be);
        bit done = 0;
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        wr_be    = be;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (wr_ready) done = 1;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL write_accept: got wr_ready=0 for 200 cycles, required 1");
        end
        @(posedge clk);
        #1 wr_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit done = 0;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            if (!mem_valid) done = 1;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL drain: got mem_valid=1 after 100 cycles, required 0");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
        mem_ready = 1'b0; vec_en = '0; vec_addr = '0; vec_data = '0; intr_clr = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({wr_ready, mem_valid, mem_addr, mem_data, mem_be} !== {1'b1, 1'b0, 64'h0, 32'h0, 4'h0}) begin
            failures++;
            $display("FAIL reset_port: got rdy=%b vld=%b addr=%h data=%h be=%h required 1 0 0 0 0",
                     wr_ready, mem_valid, mem_addr, mem_data, mem_be);
        end
        checks++;
        if ({intr_pend, intr_any, hit_cnt} !== '0) begin
            failures++;
            $display("FAIL reset_intr: got pend=%b any=%b cnt=%h required 0", intr_pend, intr_any, hit_cnt);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_in_order();
        int r0 = retired;
        mem_ready = 1'b1;
        wr_valid = 1'b1; wr_addr = 64'h100; wr_data = 32'hA0; wr_be = 4'hF;
        @(negedge clk);
        checks++;
        if (mem_valid !== 1'b0) begin
            failures++;
            $display("FAIL latency_pre: got mem_valid=%b required 0", mem_valid);
        end
        @(posedge clk);
        #1 wr_addr = 64'h104; wr_data = 32'hA4;
        @(negedge clk);
        checks++;
        if (mem_valid !== 1'b1 || mem_addr !== 64'h100) begin
            failures++;
            $display("FAIL latency_first: got vld=%b addr=%h required 1 100", mem_valid, mem_addr);
        end
        @(posedge clk);
        #1 wr_addr = 64'h108; wr_data = 32'hA8;
        @(posedge clk);
        #1 wr_valid = 1'b0;
        wait_drain();
        checks++;
        if (retired - r0 != 3 || intr_pend !== 4'h0) begin
            failures++;
            $display("FAIL in_order: got retired=%0d pend=%b required 3 0000", retired - r0, intr_pend);
        end
    endtask

    task automatic test_match_clear();
        vec_addr[63:0] = 64'h1; vec_data[31:0] = 32'h12345678; vec_en = 4'b0001;
        do_write(64'h1, 32'h12345678, 4'hF);
        @(negedge clk);
        checks++;
        if (mem_valid !== 1'b1 || intr_pend[0] !== 1'b0) begin
            failures++;
            $display("FAIL match_pop_cycle: got vld=%b pend0=%b required 1 0", mem_valid, intr_pend[0]);
        end
        @(negedge clk);
        checks++;
        if (intr_pend[0] !== 1'b1 || intr_any !== 1'b1 || hit_cnt[15:0] !== 16'd1) begin
            failures++;
            $display("FAIL match_set: got pend0=%b any=%b cnt0=%0d required 1 1 1",
                     intr_pend[0], intr_any, hit_cnt[15:0]);
        end
        @(posedge clk);
        #1 intr_clr = 4'b0001;
        @(posedge clk);
        #1 intr_clr = 4'b0000;
        @(negedge clk);
        checks++;
        if (intr_pend[0] !== 1'b0 || intr_any !== 1'b0) begin
            failures++;
            $display("FAIL match_clear: got pend0=%b any=%b required 0 0", intr_pend[0], intr_any);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_full_backpressure();
        int r0 = retired;
        mem_ready = 1'b0;
        for (int i = 0; i < 8; i++) do_write(64'h200 + 64'(4 * i), $urandom, 4'hF);
        @(negedge clk);
        checks++;
        if (wr_ready !== 1'b0 || mem_addr !== 64'h200) begin
            failures++;
            $display("FAIL full: got rdy=%b head=%h required 0 200", wr_ready, mem_addr);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (mem_valid !== 1'b1 || mem_addr !== 64'h200) begin
            failures++;
            $display("FAIL stall_stable: got vld=%b head=%h required 1 200", mem_valid, mem_addr);
        end
        @(posedge clk);
        #1 mem_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1 mem_ready = 1'b0;
        wr_valid = 1'b1; wr_addr = 64'h220; wr_data = $urandom; wr_be = 4'hF; mem_ready = 1'b1;
        @(posedge clk);
        #1 wr_valid = 1'b0; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) do_write(64'h224 + 64'(4 * i), $urandom, 4'hF);
        @(negedge clk);
        checks++;
        if (wr_ready !== 1'b1) begin
            failures++;
            $display("FAIL count_7: got wr_ready=%b required 1", wr_ready);
        end
        @(posedge clk);
        #1 do_write(64'h230, $urandom, 4'hF);
        @(negedge clk);
        checks++;
        if (wr_ready !== 1'b0) begin
            failures++;
            $display("FAIL push_pop_count: got wr_ready=%b required 0", wr_ready);
        end
        @(posedge clk);
        #1 mem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (wr_ready !== 1'b0) begin
            failures++;
            $display("FAIL full_no_bypass: got wr_ready=%b required 0", wr_ready);
        end
        @(negedge clk);
        checks++;
        if (wr_ready !== 1'b1) begin
            failures++;
            $display("FAIL full_release: got wr_ready=%b required 1", wr_ready);
        end
        @(posedge clk);
        #1;
        wait_drain();
        checks++;
        if (retired - r0 != 13 || sb.size() != 0) begin
            failures++;
            $display("FAIL full_retire: got retired=%0d left=%0d required 13 0", retired - r0, sb.size());
        end
    endtask

    task automatic test_no_hit();
        do_write(64'h1, 32'h12345678, 4'h7);
        wait_drain();
        checks++;
        if (intr_pend !== 4'h0 || hit_cnt[15:0] !== 16'd1) begin
            failures++;
            $display("FAIL partial_be: got pend=%b cnt0=%0d required 0000 1", intr_pend, hit_cnt[15:0]);
        end
        vec_en = 4'b0000;
        do_write(64'h1, 32'h12345678, 4'hF);
        wait_drain();
        checks++;
        if (intr_pend !== 4'h0 || hit_cnt[15:0] !== 16'd1) begin
            failures++;
            $display("FAIL disabled_vec: got pend=%b cnt0=%0d required 0000 1", intr_pend, hit_cnt[15:0]);
        end
    endtask

    task automatic test_multi_vec();
        vec_addr[127:64] = 64'h40; vec_data[63:32] = 32'hCAFEF00D;
        vec_addr[191:128] = 64'h40; vec_data[95:64] = 32'hCAFEF00D;
        vec_en = 4'b0111;
        do_write(64'h40, 32'hCAFEF00D, 4'hF);
        repeat (2) @(negedge clk);
        checks++;
        if (intr_pend !== 4'b0110 || hit_cnt[31:16] !== 16'd1 || hit_cnt[47:32] !== 16'd1) begin
            failures++;
            $display("FAIL multi_hit: got pend=%b c1=%0d c2=%0d required 0110 1 1",
                     intr_pend, hit_cnt[31:16], hit_cnt[47:32]);
        end
        @(posedge clk);
        #1 do_write(64'h40, 32'hCAFEF00D, 4'hF);
        intr_clr = 4'b0110;
        @(posedge clk);
        #1 intr_clr = 4'b0000;
        @(negedge clk);
        checks++;
        if (intr_pend !== 4'b0110 || hit_cnt[31:16] !== 16'd2) begin
            failures++;
            $display("FAIL set_wins: got pend=%b c1=%0d required 0110 2", intr_pend, hit_cnt[31:16]);
        end
        @(posedge clk);
        #1 intr_clr = 4'b0110;
        @(posedge clk);
        #1 intr_clr = 4'b0000;
        @(negedge clk);
        checks++;
        if (intr_pend !== 4'b0000) begin
            failures++;
            $display("FAIL multi_clear: got pend=%b required 0000", intr_pend);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_saturate_and_reset();
        int n = 0;
        int guard = 0;
        vec_addr[255:192] = 64'h80; vec_data[127:96] = 32'hA5A5A5A5; vec_en = 4'b1000;
        mem_ready = 1'b1;
        wr_valid = 1'b1; wr_addr = 64'h80; wr_data = 32'hA5A5A5A5; wr_be = 4'hF;
        while (n < 65536 && guard < 70000) begin
            @(negedge clk);
            guard++;
            if (wr_ready) n++;
        end
        @(posedge clk);
        #1 wr_valid = 1'b0;
        wait_drain();
        checks++;
        if (hit_cnt[63:48] !== 16'hFFFF || intr_pend[3] !== 1'b1) begin
            failures++;
            $display("FAIL saturate_reach: got c3=%h pend3=%b required ffff 1", hit_cnt[63:48], intr_pend[3]);
        end
        do_write(64'h80, 32'hA5A5A5A5, 4'hF);
        wait_drain();
        checks++;
        if (hit_cnt[63:48] !== 16'hFFFF || hit_cnt[15:0] !== 16'd1) begin
            failures++;
            $display("FAIL saturate_hold: got c3=%h c0=%0d required ffff 1", hit_cnt[63:48], hit_cnt[15:0]);
        end
        mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) do_write(64'h300 + 64'(4 * i), $urandom, 4'hF);
        @(negedge clk);
        checks++;
        if (mem_valid !== 1'b1 || mem_addr !== 64'h300) begin
            failures++;
            $display("FAIL prereset_fill: got vld=%b head=%h required 1 300", mem_valid, mem_addr);
        end
        @(posedge clk);
        #3 rst_n = 1'b0;
        sb.delete();
        #1;
        checks++;
        if ({wr_ready, mem_valid, mem_addr, mem_data, mem_be, intr_pend, intr_any, hit_cnt} !==
            {1'b1, 1'b0, 64'h0, 32'h0, 4'h0, 4'h0, 1'b0, 64'h0}) begin
            failures++;
            $display("FAIL midop_reset: got rdy=%b vld=%b addr=%h pend=%b any=%b cnt=%h required 1 0 0 0 0 0",
                     wr_ready, mem_valid, mem_addr, intr_pend, intr_any, hit_cnt);
        end
        @(posedge clk);
        #1 rst_n = 1'b1; mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (mem_valid !== 1'b0 || wr_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_discard: got vld=%b rdy=%b required 0 1", mem_valid, wr_ready);
        end
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_match_clear();
        test_full_backpressure();
        test_no_hit();
        test_multi_vec();
        test_saturate_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
